board_slide_engine: RTL and testbench
=====================================

BOARD_SLIDE_ENGINE -- requirements
Module: board_slide_engine

Interface
REQ-001 Parameter N, default 4, board dimension (rows = columns), legal range 2..8.
REQ-002 Parameter W, default 4, cell width; a cell holds a tile exponent, 0 = empty, e>0 = tile value 2^e.
REQ-003 Parameter SW, default 20, score width.
REQ-004 Parameter WIN_EXP, default 11, exponent that flags a win; legal range 1..2^W-1.
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 enable  in  1  when high, the FSM advances; when low, all state and outputs hold.
REQ-008 start  in  1  move request, sampled in IDLE with enable high.
REQ-009 direction  in  2  00 up, 01 down, 10 left, 11 right; row 0 = top, column 0 = left.
REQ-010 board_in  in  [0:N-1][0:N-1] x W  source board, sampled with start.
REQ-011 board_out  out  [0:N-1][0:N-1] x W  result board, registered.
REQ-012 busy  out  1  high from the cycle after start acceptance until done.
REQ-013 movement_done  out  1  one-cycle pulse; the result is valid.
REQ-014 moved  out  1  board_out differs from the captured board_in; valid with movement_done and held until the next move.
REQ-015 score_delta  out  SW  sum of merged tile values for the last move; held.
REQ-016 win  out  1  a merge in the last move produced an exponent >= WIN_EXP; held.

Function
REQ-017 FSM states: IDLE, PROC, DONE; when enable is low, all transitions are suppressed.
REQ-018 IDLE with start=1: capture board_in and direction into internal registers, clear the line counter, score accumulator, and win accumulator, then go to PROC.
REQ-019 PROC: process one line per cycle; the line index goes 0..N-1; go to DONE after line N-1.
REQ-020 Line selection:
- up/down use column k; left/right use row k.
- Cells are read toward the move direction: up = row 0 first, down = row N-1 first, left = column 0 first, right = column N-1 first.
REQ-021 Line operation, three steps:
- compress non-zero tiles toward the lead end;
- merge adjacent equal pairs scanning from the lead end, each tile merging at most once per move;
- compress again.
REQ-022 A merge of two tiles of exponent e writes e+1 and adds 2^(e+1) to the score accumulator.
REQ-023 Saturation rules:
- Tiles with e = 2^W-1 never merge.
- The score accumulator saturates at 2^SW-1.
REQ-024 The processed line is written into an internal result board at its original positions.
REQ-025 DONE: load the result into board_out, assert movement_done for exactly one cycle, and update moved, score_delta and win; return to IDLE.
REQ-026 Latency: movement_done rises N+1 enabled cycles after the start-acceptance edge.
REQ-027 start while busy is ignored and is not queued.
REQ-028 If start and movement_done coincide, the new start is not accepted, because the FSM is not in IDLE.
REQ-029 A board with no legal move yields board_out equal to the captured board, moved=0, score_delta=0, still with a movement_done pulse.
REQ-030 Changes to board_in after capture have no effect on the result in progress.

Reset
REQ-031 While rst=0:
- FSM = IDLE; board_out all zero; busy, movement_done, moved and win are 0; score_delta is 0.
- All internal registers are cleared.
REQ-032 Reset during PROC aborts the move; no movement_done pulse follows deassertion.
REQ-033 Deassertion is expected to be synchronous to clk externally; the block adds no reset synchroniser.

Configuration
REQ-034 Macro BOARD_SLIDE_SCORE_EN, when defined, compiles in the score accumulator, score_delta and win logic.
REQ-035 Without BOARD_SLIDE_SCORE_EN, score_delta is tied to 0, win is tied to 0, no accumulator is built, and board behaviour is identical.

Verification (N=4, W=4, SCORE_EN defined)
REQ-036 Start, left, row0=[1,1,2,2], other rows zero -> row0 out [2,3,0,0], score_delta=12, moved=1, movement_done at cycle 5.
REQ-037 Start, left, row0=[2,2,2,0] -> [3,2,0,0], score_delta=8; start, right on the same board -> [0,0,2,3], score_delta=8.
REQ-038 Start, up, column0 top-down=[1,0,1,3] -> [2,3,0,0], score_delta=4; column0 top-down=[10,10,0,0] -> [11,0,0,0], win=1.
REQ-039 Start, left, row0=[15,15,0,0] -> unchanged, moved=0, score_delta=0; a compacted board with no pairs -> moved=0.
REQ-040 Start accepted, then rst low on the 2nd PROC cycle -> all outputs zero, no movement_done after release; start during busy -> ignored.
REQ-041 Start accepted, enable low for 3 cycles mid-PROC -> movement_done delayed by exactly 3 cycles with the result unchanged.

Source files
------------

// File: rtl/board_slide_engine.sv
// Slides and merges an NxN board of tile exponents one line per cycle. Optional scoring logic is built when BOARD_SLIDE_SCORE_EN is defined.
// Latency: movement_done rises N+1 enabled cycles after start is accepted. Start is ignored while busy, and enable low freezes everything.
module board_slide_engine #(
    parameter int N       = 4,
    parameter int W       = 4,
    parameter int SW      = 20,
    parameter int WIN_EXP = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         start,
    input  logic [1:0]                   direction,
    input  logic [0:N-1][0:N-1][W-1:0]   board_in,
    output logic [0:N-1][0:N-1][W-1:0]   board_out,
    output logic                         busy,
    output logic                         movement_done,
    output logic                         moved,
    output logic [SW-1:0]                score_delta,
    output logic                         win
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PROC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int         IW     = $clog2(N);
    localparam logic [W-1:0] E_MAX = '1;

    logic [1:0]                 state;
    logic [IW-1:0]              idx;
    logic [1:0]                 dir_q;
    logic [0:N-1][0:N-1][W-1:0] cap;
    logic [0:N-1][0:N-1][W-1:0] res;
    logic [0:N-1][W-1:0]        line_in;
    logic [0:N-1][W-1:0]        cmp;
    logic [0:N-1][W-1:0]        mrg;
    logic [0:N-1][W-1:0]        line_out;

`ifdef BOARD_SLIDE_SCORE_EN
    localparam logic [W-1:0] WIN_E = W'(WIN_EXP);
    logic [SW-1:0] line_score;
    logic          line_win;
    logic [SW-1:0] acc;
    logic          win_acc;

    function automatic logic [SW-1:0] tile_val(input logic [W-1:0] e);
        if (int'(e) >= SW) return '1;
        return SW'(1) << e;
    endfunction

    function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SW] ? '1 : s[SW-1:0];
    endfunction
`endif

    // Element 0 of line_in is always the lead end of the move.
    always_comb begin
        line_in = '0;
        for (int i = 0; i < N; i++) begin
            case (dir_q)
                2'b00:   line_in[i] = cap[i][idx];
                2'b01:   line_in[i] = cap[N-1-i][idx];
                2'b10:   line_in[i] = cap[idx][i];
                default: line_in[i] = cap[idx][N-1-i];
            endcase
        end
    end

    always_comb begin
        int j;
        cmp      = '0;
        line_out = '0;
`ifdef BOARD_SLIDE_SCORE_EN
        line_score = '0;
        line_win   = 1'b0;
`endif
        j = 0;
        for (int i = 0; i < N; i++) begin
            if (line_in[i] != '0) begin
                cmp[j] = line_in[i];
                j++;
            end
        end
        // Zeroing the absorbed partner stops it from merging again.
        mrg = cmp;
        for (int i = 0; i < N - 1; i++) begin
            if (mrg[i] != '0 && mrg[i] == mrg[i+1] && mrg[i] != E_MAX) begin
                mrg[i]   = mrg[i] + 1'b1;
                mrg[i+1] = '0;
`ifdef BOARD_SLIDE_SCORE_EN
                line_score = sat_add(line_score, tile_val(mrg[i]));
                if (mrg[i] >= WIN_E) line_win = 1'b1;
`endif
            end
        end
        j = 0;
        for (int i = 0; i < N; i++) begin
            if (mrg[i] != '0) begin
                line_out[j] = mrg[i];
                j++;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            idx           <= '0;
            dir_q         <= 2'b00;
            cap           <= '0;
            res           <= '0;
            board_out     <= '0;
            busy          <= 1'b0;
            movement_done <= 1'b0;
            moved         <= 1'b0;
        end else if (enable) begin
            movement_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cap   <= board_in;
                        dir_q <= direction;
                        idx   <= '0;
                        res   <= '0;
                        busy  <= 1'b1;
                        state <= S_PROC;
                    end
                end
                S_PROC: begin
                    for (int i = 0; i < N; i++) begin
                        case (dir_q)
                            2'b00:   res[i][idx]     <= line_out[i];
                            2'b01:   res[N-1-i][idx] <= line_out[i];
                            2'b10:   res[idx][i]     <= line_out[i];
                            default: res[idx][N-1-i] <= line_out[i];
                        endcase
                    end
                    idx <= idx + 1'b1;
                    if (idx == IW'(N - 1)) state <= S_DONE;
                end
                S_DONE: begin
                    board_out     <= res;
                    movement_done <= 1'b1;
                    moved         <= (res != cap);
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BOARD_SLIDE_SCORE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc         <= '0;
            win_acc     <= 1'b0;
            score_delta <= '0;
            win         <= 1'b0;
        end else if (enable) begin
            if (state == S_IDLE && start) begin
                acc     <= '0;
                win_acc <= 1'b0;
            end else if (state == S_PROC) begin
                acc     <= sat_add(acc, line_score);
                win_acc <= win_acc | line_win;
            end else if (state == S_DONE) begin
                score_delta <= acc;
                win         <= win_acc;
            end
        end
    end
`else
    assign score_delta = '0;
    assign win         = 1'b0;
`endif

endmodule

// File: tb/tb_board_slide_engine.sv
// Directed bench for board_slide_engine (N=4, W=4); score/win expectations follow BOARD_SLIDE_SCORE_EN.
module tb_board_slide_engine;
    typedef logic [0:3][0:3][3:0] brd_t;

`ifdef BOARD_SLIDE_SCORE_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  direction = 2'b00;
    brd_t        board_in = '0;
    brd_t        board_out;
    logic        busy;
    logic        movement_done;
    logic        moved;
    logic [19:0] score_delta;
    logic        win;

    int checks = 0;
    int errors = 0;

    board_slide_engine #(.N(4), .W(4), .SW(20), .WIN_EXP(11)) dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .direction(direction),
        .board_in(board_in), .board_out(board_out), .busy(busy),
        .movement_done(movement_done), .moved(moved), .score_delta(score_delta), .win(win)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (movement_done) cnt++;
        end
    endtask

    task automatic run_move(input string tag, input brd_t bi, input logic [1:0] d, input int stall,
                            input brd_t eb, input int es, input bit em, input bit ew, input int elat);
        int cyc;
        @(negedge clk);
        board_in  = bi;
        direction = d;
        start     = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        board_in = '1;
        check({tag, ":busy"}, 64'(busy), 64'd1);
        cyc = 0;
        while (cyc < 40) begin
            if (cyc == 2 && stall > 0) begin
                enable = 1'b0;
                repeat (stall) begin
                    @(posedge clk); #1;
                    cyc++;
                end
                enable = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (movement_done) break;
        end
        check({tag, ":done"}, 64'(movement_done), 64'd1);
        check({tag, ":lat"}, 64'(cyc), 64'(elat));
        check({tag, ":board"}, 64'(board_out), 64'(eb));
        check({tag, ":moved"}, 64'(moved), 64'(em));
        check({tag, ":score"}, 64'(score_delta), SC ? 64'(es) : 64'd0);
        check({tag, ":win"}, 64'(win), SC ? 64'(ew) : 64'd0);
        @(posedge clk); #1;
        check({tag, ":pulse"}, 64'(movement_done), 64'd0);
        check({tag, ":idle"}, 64'(busy), 64'd0);
        check({tag, ":hold"}, 64'(moved), 64'(em));
    endtask

    initial begin
        brd_t b, e;
        int   n;

        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst:board", 64'(board_out), 64'd0);
        check("rst:busy", 64'(busy), 64'd0);
        check("rst:done", 64'(movement_done), 64'd0);
        check("rst:moved", 64'(moved), 64'd0);
        check("rst:score", 64'(score_delta), 64'd0);
        check("rst:win", 64'(win), 64'd0);
        @(negedge clk) rst = 1'b1;

        b = '0; b[0] = {4'd1, 4'd1, 4'd2, 4'd2};
        e = '0; e[0] = {4'd2, 4'd3, 4'd0, 4'd0};
        run_move("left1122", b, 2'b10, 0, e, 12, 1'b1, 1'b0, 5);

        b = '0; b[0] = {4'd2, 4'd2, 4'd2, 4'd0};
        e = '0; e[0] = {4'd3, 4'd2, 4'd0, 4'd0};
        run_move("left2220", b, 2'b10, 0, e, 8, 1'b1, 1'b0, 5);
        e = '0; e[0] = {4'd0, 4'd0, 4'd2, 4'd3};
        run_move("right2220", b, 2'b11, 0, e, 8, 1'b1, 1'b0, 5);

        b = '0; b[0][0] = 4'd1; b[2][0] = 4'd1; b[3][0] = 4'd3;
        e = '0; e[0][0] = 4'd2; e[1][0] = 4'd3;
        run_move("up1013", b, 2'b00, 0, e, 4, 1'b1, 1'b0, 5);

        b = '0; b[0][0] = 4'd1; b[1][0] = 4'd1; b[2][0] = 4'd1; b[3][0] = 4'd1;
        e = '0; e[2][0] = 4'd2; e[3][0] = 4'd2;
        run_move("down1111", b, 2'b01, 0, e, 8, 1'b1, 1'b0, 5);

        b = '0; b[0][0] = 4'd10; b[1][0] = 4'd10;
        e = '0; e[0][0] = 4'd11;
        run_move("upwin", b, 2'b00, 0, e, 2048, 1'b1, 1'b1, 5);

        // Abort with reset on the second processing cycle.
        b = '0; b[0] = {4'd1, 4'd1, 4'd0, 4'd0};
        @(negedge clk);
        board_in = b; direction = 2'b10; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        #1;
        check("abort:board", 64'(board_out), 64'd0);
        check("abort:busy", 64'(busy), 64'd0);
        check("abort:moved", 64'(moved), 64'd0);
        check("abort:score", 64'(score_delta), 64'd0);
        check("abort:win", 64'(win), 64'd0);
        @(negedge clk); @(negedge clk) rst = 1'b1;
        count_done(10, n);
        check("abort:nodone", 64'(n), 64'd0);
        check("abort:idle", 64'(busy), 64'd0);

        b = '0; b[0] = {4'd15, 4'd15, 4'd0, 4'd0};
        run_move("sat15", b, 2'b10, 0, b, 0, 1'b0, 1'b0, 5);

        b = '0; b[0] = {4'd1, 4'd2, 4'd3, 4'd4}; b[1] = {4'd2, 4'd1, 4'd0, 4'd0}; b[2] = {4'd5, 4'd0, 4'd0, 4'd0};
        run_move("nomove", b, 2'b10, 0, b, 0, 1'b0, 1'b0, 5);

        // Start held high through the whole move: neither re-accepted while busy nor at the done edge.
        b = '0; b[0] = {4'd1, 4'd1, 4'd0, 4'd0};
        e = '0; e[0] = {4'd2, 4'd0, 4'd0, 4'd0};
        @(negedge clk);
        board_in = b; direction = 2'b10; start = 1'b1;
        @(posedge clk); #1;
        board_in = '0; board_in[0] = {4'd3, 4'd3, 4'd3, 4'd3};
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (movement_done) break;
        end
        start = 1'b0;
        check("held:lat", 64'(n), 64'd5);
        check("held:board", 64'(board_out), 64'(e));
        check("held:score", 64'(score_delta), SC ? 64'd4 : 64'd0);
        count_done(10, n);
        check("held:nodone", 64'(n), 64'd0);
        check("held:idle", 64'(busy), 64'd0);

        b = '0; b[0] = {4'd1, 4'd1, 4'd2, 4'd2};
        e = '0; e[0] = {4'd2, 4'd3, 4'd0, 4'd0};
        run_move("stall3", b, 2'b10, 3, e, 12, 1'b1, 1'b0, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
